// File: rtl/key_step_gen.sv
// key_step_gen: turns a bouncy active-low push-button into a clean active-low step level
// for a negedge-clocked register bank, with an optional free-running auto-run mode.
//
// Ports:
//   clk        board oscillator; all state updates on its rising edge
//   reset      asynchronous active-low clear
//   key_n      raw push-button, active-low, asynchronous to clk
//   run_en     selects auto-run stepping when high
//   step_n     registered active-low step level (idle 1)
//   step_pulse registered one-cycle strobe on every falling edge of step_n
//   step_count registered 16-bit count of step_n falling edges (wraps)
module key_step_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned RUN_HALF        = 12500000,
    parameter int unsigned CNT_WIDTH       = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_n,
    input  logic        run_en,
    output logic        step_n,
    output logic        step_pulse,
    output logic [15:0] step_count
);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    localparam logic [CNT_WIDTH-1:0] DB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RUN_LAST = CNT_WIDTH'(RUN_HALF - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 s1, s2;
    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    // Set while the current HELD phase is an auto-run low phase; keeps it running to its
    // full length even if run_en drops, so no runt clock pulse is produced.
    logic                 auto_q, auto_d;
    logic                 step_n_d, step_pulse_d;
    logic [15:0]          step_count_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        auto_d       = auto_q;
        step_n_d     = step_n;
        step_pulse_d = 1'b0;
        step_count_d = step_count;

        unique case (state_q)
            IDLE: begin
                if (run_en) begin
                    if (cnt_q == RUN_LAST) begin
                        state_d      = HELD;
                        cnt_d        = CNT_ZERO;
                        auto_d       = 1'b1;
                        step_n_d     = 1'b0;
                        step_pulse_d = 1'b1;
                        step_count_d = step_count + 16'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (!s2) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    // Discards a partial auto-run high phase when run_en drops.
                    cnt_d = CNT_ZERO;
                end
            end
            PRESS_WAIT: begin
                if (s2) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DB_LAST) begin
                    state_d      = HELD;
                    cnt_d        = CNT_ZERO;
                    auto_d       = 1'b0;
                    step_n_d     = 1'b0;
                    step_pulse_d = 1'b1;
                    step_count_d = step_count + 16'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (run_en || auto_q) begin
                    auto_d = 1'b1;
                    if (cnt_q == RUN_LAST) begin
                        state_d  = IDLE;
                        cnt_d    = CNT_ZERO;
                        auto_d   = 1'b0;
                        step_n_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (s2) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (!s2) begin
                    state_d = HELD;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DB_LAST) begin
                    state_d  = IDLE;
                    cnt_d    = CNT_ZERO;
                    step_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1         <= 1'b1;
            s2         <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= CNT_ZERO;
            auto_q     <= 1'b0;
            step_n     <= 1'b1;
            step_pulse <= 1'b0;
            step_count <= 16'd0;
        end else begin
            s1         <= key_n;
            s2         <= s1;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            auto_q     <= auto_d;
            step_n     <= step_n_d;
            step_pulse <= step_pulse_d;
            step_count <= step_count_d;
        end
    end

endmodule
